bcd_display_mux: RTL and testbench

- Time-multiplexed 7-segment display driver sitting directly downstream of the BCD up-counter stages.
- Captures a packed multi-digit BCD word into a shadow register and scans one digit at a time at a programmable refresh rate.
- Decodes each digit to segments, with optional leading-zero blanking and a one-cycle anti-ghosting blank between digits.
- Drives the board's common-anode display pins directly.

---
 rtl/bcd_display_pkg.sv | 25 ++
 rtl/bcd_to_7seg.sv | 29 ++
 rtl/bcd_display_mux.sv | 128 ++++++++++++
 tb/tb_bcd_display_mux.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared segment patterns and helpers for the multiplexed 7-segment driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_display_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // One-hot digit select for up to 8 digits; callers truncate to their width.
  function automatic logic [7:0] onehot_digit(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder (active-high segments).
// Ports:
//   bcd   - 4-bit BCD digit
//   seg_c - segments {g,f,e,d,c,b,a}; codes 10..15 show a dash
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 7-segment display driver for a packed multi-digit BCD word.
// Each digit slot is REFRESH_DIV cycles: REFRESH_DIV-1 lit cycles followed by
// one all-dark cycle that keeps the previous digit from ghosting onto the next.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture bcd_in/dp_in into the shadow register
//   bcd_in     - packed BCD, digit 0 (rightmost) in [3:0]
//   dp_in      - decimal-point request per digit
//   blank_lz   - enable leading-zero blanking
//   seg, dp    - segment and decimal-point pins (polarity per SEG_ACTIVE_LOW)
//   an         - digit enables (polarity per AN_ACTIVE_LOW)
//   frame_done - one-cycle pulse as the scan wraps back to digit 0
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0]  LAST_PRE = PRE_W'(REFRESH_DIV - 1);
  localparam logic [SEG_W-1:0]  SEG_OFF  = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   shadow_dp;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;

  logic                tick_c;
  logic [DIGITS-1:0]   lz_c;
  logic                lz_run;
  logic [3:0]          cur_bcd_c;
  logic                cur_dp_c;
  logic                cur_lz_c;
  logic [SEG_W-1:0]    dec_c;
  logic                blank_c;
  logic [SEG_W-1:0]    seg_hi_c;
  logic                dp_hi_c;
  logic [DIGITS-1:0]   an_lit_c;

  assign tick_c = (presc == LAST_PRE);

  // lz_c[i]: every digit from the top down to i is zero with no dp request.
  always_comb begin
    lz_c   = '0;
    lz_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      lz_run = lz_run && (shadow[4*i +: 4] == 4'd0) && !shadow_dp[i];
      lz_c[i] = lz_run;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_bcd_c = '0;
    cur_dp_c  = 1'b0;
    cur_lz_c  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_bcd_c = shadow[4*i +: 4];
        cur_dp_c  = shadow_dp[i];
        cur_lz_c  = lz_c[i];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd   (cur_bcd_c),
    .seg_c (dec_c)
  );

  always_comb begin
    blank_c  = blank_lz && cur_lz_c;
    seg_hi_c = blank_c ? SEG_BLANK : dec_c;
    dp_hi_c  = cur_dp_c && !blank_c;
    an_lit_c = DIGITS'(onehot_digit(3'(idx)));
  end

  // Scan state, shadow register and polarity-adjusted output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      shadow_dp  <= '0;
      presc      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
    end else begin
      if (load) begin
        shadow    <= bcd_in;
        shadow_dp <= dp_in;
      end
      if (tick_c) begin
        presc      <= '0;
        idx        <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        an         <= AN_OFF;
        frame_done <= (idx == LAST_IDX);
      end else begin
        presc      <= presc + PRE_W'(1);
        an         <= AN_ACTIVE_LOW ? ~an_lit_c : an_lit_c;
        seg        <= SEG_ACTIVE_LOW ? ~seg_hi_c : seg_hi_c;
        dp         <= SEG_ACTIVE_LOW ? ~dp_hi_c : dp_hi_c;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux: DIGITS=4, REFRESH_DIV=4, active-low pins.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_display_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_display_mux #(
    .DIGITS         (4),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // Reset, then load a value on the first edge after release.
  // Returns at the falling edge following that first edge (scan cycle n=1).
  task automatic reset_and_load(input logic [15:0] v, input logic [3:0] d,
                                input logic lz);
    rst = 1'b1; load = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; load = 1'b1; bcd_in = v; dp_in = d; blank_lz = lz;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got=%b exp=%b", an, 4'hF); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got=%h exp=%h", seg, 7'h7F); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b exp=1", dp); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
  endtask

  // 1234 over 20 cycles: lit/dark pattern, anode rotation, frame_done cadence.
  task automatic test_scan;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    logic       exp_fd;
    int         fd_count;
    exp_seg[0] = ~7'h66; exp_seg[1] = ~7'h4F; exp_seg[2] = ~7'h5B; exp_seg[3] = ~7'h06;
    fd_count = 0;
    reset_and_load(16'h1234, 4'b0000, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      int slot, ph;
      slot   = ((n - 1) / 4) % 4;
      ph     = (n - 1) % 4;
      exp_an = (ph == 3) ? 4'hF : ~(4'b0001 << slot);
      exp_fd = (n % 16 == 0);
      if (n >= 5 && frame_done === 1'b1) fd_count++;
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an n=%0d got=%b exp=%b", n, an, exp_an); end
      n_checks++; if (frame_done !== exp_fd) begin n_fail++; $display("FAIL scan_fd n=%0d got=%b exp=%b", n, frame_done, exp_fd); end
      if (ph != 3 && n > 1) begin
        n_checks++; if (seg !== exp_seg[slot]) begin n_fail++; $display("FAIL scan_seg n=%0d got=%h exp=%h", n, seg, exp_seg[slot]); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL scan_dp n=%0d got=%b exp=1", n, dp); end
      end
      @(negedge clk);
    end
    n_checks++; if (fd_count != 1) begin n_fail++; $display("FAIL scan_fd_count got=%0d exp=1", fd_count); end
  endtask

  // 0070 with and without leading-zero blanking.
  task automatic test_blank_lz;
    logic [6:0] exp_seg [4];
    for (int pass = 0; pass < 2; pass++) begin
      exp_seg[0] = ~7'h3F; exp_seg[1] = ~7'h07;
      exp_seg[2] = (pass == 0) ? 7'h7F : ~7'h3F;
      exp_seg[3] = (pass == 0) ? 7'h7F : ~7'h3F;
      reset_and_load(16'h0070, 4'b0000, (pass == 0));
      for (int n = 1; n <= 16; n++) begin
        int slot, ph;
        slot = ((n - 1) / 4) % 4;
        ph   = (n - 1) % 4;
        if (ph != 3 && n > 1) begin
          n_checks++; if (seg !== exp_seg[slot]) begin n_fail++; $display("FAIL lz_seg pass=%0d n=%0d got=%h exp=%h", pass, n, seg, exp_seg[slot]); end
          n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL lz_dp pass=%0d n=%0d got=%b exp=1", pass, n, dp); end
        end
        @(negedge clk);
      end
    end
  endtask

  // 00A0 with dp on digit 2: dp stops blanking, invalid code shows a dash.
  task automatic test_dp_dash;
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    exp_seg[0] = ~7'h3F; exp_seg[1] = ~7'h40; exp_seg[2] = ~7'h3F; exp_seg[3] = 7'h7F;
    exp_dp[0]  = 1'b1;   exp_dp[1]  = 1'b1;   exp_dp[2]  = 1'b0;   exp_dp[3]  = 1'b1;
    reset_and_load(16'h00A0, 4'b0100, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      int slot, ph;
      slot = ((n - 1) / 4) % 4;
      ph   = (n - 1) % 4;
      if (ph != 3 && n > 1) begin
        n_checks++; if (seg !== exp_seg[slot]) begin n_fail++; $display("FAIL dpd_seg n=%0d got=%h exp=%h", n, seg, exp_seg[slot]); end
        n_checks++; if (dp !== exp_dp[slot]) begin n_fail++; $display("FAIL dpd_dp n=%0d got=%b exp=%b", n, dp, exp_dp[slot]); end
      end
      @(negedge clk);
    end
  endtask

  // Load on a tick cycle, then reset in the middle of digit 2.
  task automatic test_load_tick_rst;
    reset_and_load(16'h1234, 4'b0000, 1'b0);
    @(negedge clk); @(negedge clk);
    load = 1'b1; bcd_in = 16'h5678;
    @(negedge clk);
    load = 1'b0;
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL ltr_dark_an got=%b exp=%b", an, 4'hF); end
    @(negedge clk);
    n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL ltr_d1_an got=%b exp=%b", an, 4'b1101); end
    n_checks++; if (seg !== ~7'h07) begin n_fail++; $display("FAIL ltr_d1_seg got=%h exp=%h", seg, ~7'h07); end
    repeat (4) @(negedge clk);
    n_checks++; if (an !== 4'b1011) begin n_fail++; $display("FAIL ltr_d2_an got=%b exp=%b", an, 4'b1011); end
    n_checks++; if (seg !== ~7'h7D) begin n_fail++; $display("FAIL ltr_d2_seg got=%h exp=%h", seg, ~7'h7D); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL ltr_rst_an got=%b exp=%b", an, 4'hF); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL ltr_rst_seg got=%h exp=%h", seg, 7'h7F); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL ltr_rst_fd got=%b exp=0", frame_done); end
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL ltr_post_an n=%0d got=%b exp=%b", n, an, 4'b1110); end
      n_checks++; if (seg !== ~7'h3F) begin n_fail++; $display("FAIL ltr_post_seg n=%0d got=%h exp=%h", n, seg, ~7'h3F); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL ltr_post_fd n=%0d got=%b exp=0", n, frame_done); end
    end
    @(negedge clk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL ltr_post_dark got=%b exp=%b", an, 4'hF); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_blank_lz;
    test_dp_dash;
    test_load_tick_rst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
